// File: rtl/acc_pkg.sv
// acc_pkg: widths shared across the accumulator datapath
package acc_pkg;
   localparam int ACC_WIDTH = 16;
   localparam int ACC_CNT_W = 16;
endpackage

// File: rtl/acc_diff_if.sv
// acc_diff_if: input and output stream handshakes of the differencer
interface acc_diff_if import acc_pkg::*; #(parameter int WIDTH = ACC_WIDTH);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_first;
   modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_first);
   modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_first);
endinterface

// File: rtl/acc_skid.sv
// acc_skid: output register plus one-entry skid; ready depends only on registered state
module acc_skid import acc_pkg::*; #(parameter int W = ACC_WIDTH + 1) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         push,
   input  logic [W-1:0] push_data,
   output logic         ready,
   input  logic         pop,
   output logic         valid,
   output logic [W-1:0] data
);
   logic         skid_valid;
   logic [W-1:0] skid_data;
   logic         drain, load_out, load_skid;
   assign drain     = valid & pop;
   assign load_out  = push & (~valid | (drain & ~skid_valid));
   assign load_skid = push & ~load_out;
   assign ready     = ~skid_valid;
   // output register refills from the skid first, otherwise from the incoming word
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         valid      <= 1'b0;
         data       <= '0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
      end else if (clr) begin
         valid      <= 1'b0;
         data       <= '0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
      end else begin
         if (drain & skid_valid) begin
            data  <= skid_data;
            valid <= 1'b1;
         end else if (load_out) begin
            data  <= push_data;
            valid <= 1'b1;
         end else if (drain)
            valid <= 1'b0;
         skid_valid <= load_skid | (skid_valid & ~drain);
         if (load_skid) skid_data <= push_data;
      end
endmodule

// File: rtl/acc_diff.sv
// acc_diff: turns a stream of running totals back into per-step increments
module acc_diff import acc_pkg::*; #(
   parameter int WIDTH = ACC_WIDTH,
   parameter int CNT_W = ACC_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   acc_diff_if.slave        bus,
   output logic [CNT_W-1:0] sample_cnt
);
   logic [WIDTH-1:0] prev, diff;
   logic [WIDTH:0]   out_word;
   logic             first_pend, skid_ready, accept;
   assign bus.in_ready = skid_ready & ~clr;
   assign accept       = bus.in_valid & bus.in_ready;
   assign diff         = bus.in_data - prev;
   assign {bus.out_first, bus.out_data} = out_word;
   // last total, first-sample flag and saturating accept counter
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         prev       <= '0;
         first_pend <= 1'b1;
         sample_cnt <= '0;
      end else if (clr) begin
         prev       <= '0;
         first_pend <= 1'b1;
         sample_cnt <= '0;
      end else if (accept) begin
         prev       <= bus.in_data;
         first_pend <= 1'b0;
         sample_cnt <= &sample_cnt ? sample_cnt : sample_cnt + 1'b1;
      end
   acc_skid #(.W(WIDTH + 1)) u_skid (
      .clk       (clk),
      .reset     (reset),
      .clr       (clr),
      .push      (accept),
      .push_data ({first_pend, diff}),
      .ready     (skid_ready),
      .pop       (bus.out_ready),
      .valid     (bus.out_valid),
      .data      (out_word)
   );
endmodule

// File: tb/tb_acc_diff.sv
// tb_acc_diff: vector table, directed corner sequences and random traffic against a FIFO model
module tb_acc_diff;
   logic clk, reset, clr;
   logic [15:0] cnt0;
   logic [3:0]  cnt1;
   int total, bad;
   acc_diff_if #(.WIDTH(16)) b0 ();
   acc_diff_if #(.WIDTH(16)) b1 ();
   assign b1.in_valid  = b0.in_valid;
   assign b1.in_data   = b0.in_data;
   assign b1.out_ready = b0.out_ready;
   acc_diff #(.WIDTH(16), .CNT_W(16)) u0 (.clk(clk), .reset(reset), .clr(clr), .bus(b0), .sample_cnt(cnt0));
   acc_diff #(.WIDTH(16), .CNT_W(4))  u1 (.clk(clk), .reset(reset), .clr(clr), .bus(b1), .sample_cnt(cnt1));
   initial clk = 0;
   always #5 clk = ~clk;
   typedef struct packed {logic [15:0] d; logic f;} item_t;
   typedef struct {logic c, iv; logic [15:0] d; logic ordy, ev; logic [15:0] ed; logic ef; int ecnt;} vec_t;
   item_t q[$];
   logic [15:0] got[$];
   logic [15:0] prev;
   logic first;
   int cnt;
   vec_t tbl[8];
   logic [15:0] vals[4];
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", n, a, e, $time);
      end
   endtask
   task automatic mreset();
      q.delete();
      prev = 0;
      first = 1;
      cnt = 0;
   endtask
   task automatic tick(output bit acc);
      bit rdy, drn;
      item_t it;
      #1;
      rdy = (q.size() < 2) && !clr;
      chk("in_ready", b0.in_ready, rdy);
      chk("in_ready_c4", b1.in_ready, rdy);
      chk("out_valid", b0.out_valid, q.size() > 0);
      chk("out_valid_c4", b1.out_valid, q.size() > 0);
      if (q.size() > 0) begin
         chk("out_data", b0.out_data, q[0].d);
         chk("out_first", b0.out_first, q[0].f);
         chk("out_data_c4", b1.out_data, q[0].d);
      end
      chk("cnt", cnt0, cnt > 65535 ? 65535 : cnt);
      chk("cnt_c4", cnt1, cnt > 15 ? 15 : cnt);
      acc = rdy & b0.in_valid;
      drn = (q.size() > 0) & b0.out_ready;
      @(posedge clk);
      if (clr) mreset();
      else begin
         if (drn) begin
            got.push_back(q[0].d);
            void'(q.pop_front());
         end
         if (acc) begin
            it.d = b0.in_data - prev;
            it.f = first;
            q.push_back(it);
            prev = b0.in_data;
            first = 0;
            cnt++;
         end
      end
      #1;
   endtask
   initial begin
      bit a;
      int idx, nacc;
      total = 0; bad = 0;
      reset = 0; clr = 0;
      b0.in_valid = 0; b0.in_data = 0; b0.out_ready = 1;
      mreset();
      #12;
      chk("rst_in_ready", b0.in_ready, 1);
      chk("rst_out_valid", b0.out_valid, 0);
      chk("rst_out_data", b0.out_data, 0);
      chk("rst_out_first", b0.out_first, 0);
      chk("rst_cnt", cnt0, 0);
      reset = 1;
      @(posedge clk);
      #1;
      tbl[0] = '{0, 1, 16'h0001, 1, 1, 16'h0001, 1, 1};
      tbl[1] = '{0, 1, 16'h0003, 1, 1, 16'h0002, 0, 2};
      tbl[2] = '{0, 1, 16'h0006, 1, 1, 16'h0003, 0, 3};
      tbl[3] = '{0, 0, 16'h0000, 1, 0, 16'h0000, 0, 3};
      tbl[4] = '{1, 0, 16'h0000, 1, 0, 16'h0000, 0, 0};
      tbl[5] = '{0, 1, 16'hFFFE, 1, 1, 16'hFFFE, 1, 1};
      tbl[6] = '{0, 1, 16'h0001, 1, 1, 16'h0003, 0, 2};
      tbl[7] = '{0, 0, 16'h0000, 1, 0, 16'h0000, 0, 2};
      for (int i = 0; i < 8; i++) begin
         clr = tbl[i].c; b0.in_valid = tbl[i].iv; b0.in_data = tbl[i].d; b0.out_ready = tbl[i].ordy;
         tick(a);
         chk($sformatf("tbl%0d_valid", i), b0.out_valid, tbl[i].ev);
         if (tbl[i].ev) begin
            chk($sformatf("tbl%0d_data", i), b0.out_data, tbl[i].ed);
            chk($sformatf("tbl%0d_first", i), b0.out_first, tbl[i].ef);
         end
         chk($sformatf("tbl%0d_cnt", i), cnt0, tbl[i].ecnt);
      end
      clr = 1; b0.in_valid = 0;
      tick(a);
      clr = 0;
      vals[0] = 10; vals[1] = 20; vals[2] = 30; vals[3] = 40;
      idx = 0; nacc = 0; b0.out_ready = 0;
      for (int c = 0; c < 4; c++) begin
         b0.in_valid = 1; b0.in_data = vals[idx];
         tick(a);
         if (a) begin idx++; nacc++; end
      end
      chk("bp_accepts", nacc, 2);
      chk("bp_ready_low", b0.in_ready, 0);
      got.delete();
      b0.out_ready = 1;
      for (int c = 0; c < 20 && got.size() < 4; c++) begin
         b0.in_valid = idx < 4;
         b0.in_data = idx < 4 ? vals[idx] : 16'h0;
         tick(a);
         if (a) idx++;
      end
      chk("bp_count", got.size(), 4);
      for (int i = 0; i < 4 && i < got.size(); i++) chk($sformatf("bp_out%0d", i), got[i], 10);
      b0.in_valid = 0;
      tick(a);
      b0.out_ready = 0; nacc = 0;
      for (int c = 0; c < 10 && nacc < 2; c++) begin
         b0.in_valid = 1; b0.in_data = 16'h100 * (nacc + 1);
         tick(a);
         if (a) nacc++;
      end
      chk("clr_skid_full", nacc, 2);
      clr = 1; b0.in_data = 16'h55;
      #1;
      chk("clr_ready", b0.in_ready, 0);
      tick(a);
      chk("clr_out_valid", b0.out_valid, 0);
      clr = 0; b0.out_ready = 1; b0.in_valid = 1; b0.in_data = 16'h0007;
      tick(a);
      b0.in_valid = 0;
      chk("clr_next_valid", b0.out_valid, 1);
      chk("clr_next_data", b0.out_data, 16'h0007);
      chk("clr_next_first", b0.out_first, 1);
      chk("clr_next_cnt", cnt0, 1);
      tick(a);
      b0.out_ready = 0; b0.in_valid = 1; b0.in_data = 16'h0003;
      tick(a);
      b0.in_valid = 0;
      chk("ar_pre_valid", b0.out_valid, 1);
      #2 reset = 0;
      #1;
      chk("ar_out_valid", b0.out_valid, 0);
      chk("ar_cnt", cnt0, 0);
      chk("ar_in_ready", b0.in_ready, 1);
      mreset();
      #1 reset = 1;
      b0.out_ready = 1; b0.in_valid = 1; b0.in_data = 16'h0004;
      tick(a);
      b0.in_valid = 0;
      chk("ar_next_data", b0.out_data, 16'h0004);
      chk("ar_next_first", b0.out_first, 1);
      tick(a);
      clr = 1;
      tick(a);
      clr = 0; nacc = 0;
      for (int c = 0; c < 300 && nacc < 20; c++) begin
         b0.in_valid = $urandom_range(0, 3) != 0;
         b0.in_data = 16'($urandom);
         b0.out_ready = $urandom_range(0, 1);
         tick(a);
         if (a) nacc++;
      end
      chk("sat_accepts", nacc, 20);
      chk("sat_cnt_c4", cnt1, 4'hF);
      chk("sat_cnt_c16", cnt0, 20);
      for (int c = 0; c < 400; c++) begin
         clr = $urandom_range(0, 29) == 0;
         b0.in_valid = $urandom_range(0, 1);
         b0.in_data = 16'($urandom);
         b0.out_ready = $urandom_range(0, 2) != 0;
         tick(a);
      end
      clr = 0; b0.in_valid = 0; b0.out_ready = 1;
      tick(a);
      tick(a);
      tick(a);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/acc_diff.md
# acc_diff

Streaming differencer that reverses the running-sum accumulator. It accepts a stream of accumulated totals over a valid/ready handshake and emits the per-step increment, `total[n] - total[n-1]` mod 2^WIDTH, with the pre-first-sample total taken as 0. It sits on the read side of the accumulator datapath and regenerates the original input stream for checking and downstream consumers. Throughput is one sample per cycle under backpressure, using a skid stage.

## Interface
- WIDTH, 16, data width of totals and increments
- CNT_W, 16, width of the accepted-sample counter
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- clr  in  1  synchronous restart; same effect as reset on all state
- in_valid  in  1  in_data holds a valid accumulated total
- in_ready  out  1  block can accept; transfer occurs when in_valid & in_ready
- in_data  in  WIDTH  accumulated total
- out_valid  out  1  out_data/out_first valid
- out_ready  in  1  consumer accepts; transfer occurs when out_valid & out_ready
- out_data  out  WIDTH  increment
- out_first  out  1  this output is the first since reset/clr
- sample_cnt  out  CNT_W  inputs accepted since reset/clr, saturating

## Operation
- State:
  - prev (WIDTH): last accepted total, resets to 0
  - first_pend (1): resets to 1
  - output register: out_valid, out_data, out_first
  - one-entry skid register: skid_valid, skid_data, skid_first
  - sample_cnt
- On input accept:
  - diff = in_data - prev, mod 2^WIDTH (wraps, no flag)
  - prev <= in_data
  - flag = first_pend; first_pend <= 0
  - sample_cnt increments, saturating at all-ones
- Routing of {diff, flag}:
  - If the output register is empty, or is draining this cycle with the skid empty: load the output register.
  - Otherwise: load the skid.
- Output drain with skid full: the output register loads from the skid; skid_valid <= 0.
- in_ready = ~skid_valid & ~clr. Registered term only; no combinational path from out_ready.
- First sample: prev = 0, so out_data = in_data. Example: 0x0005 gives 0x0005.
- Wrap: prev 0xFFFE, in 0x0001 gives 0x0003.
- clr = 1:
  - prev, sample_cnt, out_valid and skid_valid clear; first_pend <= 1
  - in_ready is 0, so no input accepted that cycle
  - any output pending is discarded
- reset asserted at any time, including mid-stream or with skid full: all state returns to reset values immediately; pending data is lost.

## Timing
- Reset values:
  - in_ready = 1
  - out_valid = 0, out_data = 0, out_first = 0
  - sample_cnt = 0
  - internal: prev = 0, first_pend = 1, skid empty
- Latency: input accepted at edge k gives out_valid at edge k (visible the cycle after acceptance).
- Sustained 1 sample/cycle while out_ready = 1.
- Backpressure (out_ready = 0):
  - First held cycle: output holds, one more input is absorbed into the skid.
  - Next cycle: in_ready = 0.
- Stall release: the first out_ready = 1 drains the output register and moves the skid up. in_ready returns to 1 on the following cycle.
- out_data/out_first stable while out_valid & ~out_ready.
- Ordering is strict FIFO; no sample is dropped or duplicated except by clr/reset.
- Counter saturation: at all-ones, further accepts leave sample_cnt unchanged; the data path is unaffected.

## Structure
- Shared package acc_pkg:
  - ACC_WIDTH = 16, default for WIDTH, shared with the accumulator
  - ACC_CNT_W = 16
- Sub-module acc_skid holds the output register plus the one-entry skid buffer.
  - Generic over payload width; payload = {first, data}
  - Reusable on the accumulator's input side
- Top level holds prev, first_pend, the subtractor, the counter and clr/reset gating.

## Test plan
- Reset, then feed totals 0x0001, 0x0003, 0x0006 with out_ready = 1:
  - outputs 0x0001 (first = 1), 0x0002, 0x0003 on consecutive cycles
  - sample_cnt = 3
- Wrap: totals 0xFFFE, 0x0001:
  - outputs 0xFFFE (first = 1), then 0x0003
- Backpressure, totals 10, 20, 30, 40 back-to-back, out_ready held 0 for 4 cycles:
  - in_ready falls after 2 accepts
  - on release, outputs 10, 10, 10, 10 in order, no loss
  - out_data stable while stalled
- clr mid-stream with skid full, then total 0x0007:
  - pending outputs discarded; in_ready = 0 during clr
  - next output 0x0007 with first = 1; sample_cnt = 1
- Asynchronous reset asserted between edges while out_valid = 1:
  - out_valid = 0, sample_cnt = 0 immediately
  - after release, total 0x0004 gives 0x0004 with first = 1
- Saturation, with CNT_W = 4 override: accept 20 samples:
  - sample_cnt stops at 0xF
  - differences still correct
